hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_ctrl_fwd_select.sv | 30 +++
 rtl/hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared types and helpers for the pipeline hazard controller:
//            bypass-select encoding, mul/div FSM states, register match.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // A producer matches a consumer only if it writes a real register (never $0)
  function automatic logic reg_match(input logic       wr,
                                     input logic [4:0] dst,
                                     input logic [4:0] src);
    return wr && (dst != 5'd0) && (dst == src);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_fwd_select.sv
`default_nettype none
// ============================================================================
// Module   : fwd_select
// Purpose  : Bypass select for one execute-stage source operand. The MEM
//            stage result is younger than WB, so it takes priority.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic       regwrite_M,
  input  logic [4:0] writereg_M,
  input  logic       regwrite_W,
  input  logic [4:0] writereg_W,
  output fwd_sel_t   sel
);

  // Priority compare: MEM first, then WB, otherwise the register file value
  always_comb begin
    sel = FWD_REG;
    if (reg_match(regwrite_M, writereg_M, src)) begin
      sel = FWD_MEM;
    end else if (reg_match(regwrite_W, writereg_W, src)) begin
      sel = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Hazard controller for the 5-stage MIPS core: execute-stage
//            bypass selects, load-use stall, taken-branch flush and the
//            multi-cycle mul/div hold of the execute stage.
//            Optional macro HAZARD_PERF_EN adds stall/flush cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [4:0]  rs_E,
  input  logic [4:0]  rt_E,
  input  logic [4:0]  writereg_E,
  input  logic [4:0]  writereg_M,
  input  logic [4:0]  writereg_W,
  input  logic        regwrite_E,
  input  logic        regwrite_M,
  input  logic        regwrite_W,
  input  logic        memtoreg_E,
  input  logic        pcsrc_E,
  input  logic        md_start_E,
  output logic [1:0]  forward_A,
  output logic [1:0]  forward_B,
  output logic        stall_F,
  output logic        stall_D,
  output logic        stall_E,
  output logic        flush_D,
  output logic        flush_E,
  output logic        flush_M,
  output logic        md_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  fwd_sel_t         sel_a;
  fwd_sel_t         sel_b;
  md_state_t        state;
  md_state_t        state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             md_done;
  logic             md_done_n;
  logic             md_stall;
  logic             lwstall;
  logic             lw_eff;
  logic             br_eff;
  logic             busy;

  fwd_select u_fwd_a (
    .src        (rs_E),
    .regwrite_M (regwrite_M),
    .writereg_M (writereg_M),
    .regwrite_W (regwrite_W),
    .writereg_W (writereg_W),
    .sel        (sel_a)
  );

  fwd_select u_fwd_b (
    .src        (rt_E),
    .regwrite_M (regwrite_M),
    .writereg_M (writereg_M),
    .regwrite_W (regwrite_W),
    .writereg_W (writereg_W),
    .sel        (sel_b)
  );

  // Load in E whose destination is read by the instruction in D
  assign lwstall = memtoreg_E &&
                   (reg_match(regwrite_E, writereg_E, rs_D) ||
                    reg_match(regwrite_E, writereg_E, rt_D));

  // While BUSY the E instruction is frozen, so branch/load-use are ignored;
  // a taken branch overrides load-use in the same cycle.
  assign busy   = (state == BUSY);
  assign br_eff = pcsrc_E && !busy;
  assign lw_eff = lwstall && !pcsrc_E && !busy;

  // State register: cnt holds the stall cycles still owed after the current
  // one; md_done marks the cycle the finished op advances out of E so its
  // still-asserted md_start_E does not restart the sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      md_done <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      md_done <= md_done_n;
    end
  end

  // Next-state logic and the mul/div stall request
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    md_done_n = 1'b0;
    md_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (md_start_E && !pcsrc_E && !md_done) begin
          md_stall = 1'b1;
          if (MD_LATENCY > 2) begin
            state_n = BUSY;
            cnt_n   = CNT_W'(MD_LATENCY - 2);
          end else begin
            md_done_n = 1'b1;
          end
        end
      end
      BUSY: begin
        md_stall = 1'b1;
        if (cnt <= CNT_W'(1)) begin
          state_n   = IDLE;
          cnt_n     = '0;
          md_done_n = 1'b1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Same-cycle outputs, all forced low while reset is asserted
  assign forward_A = reset ? 2'b00 : sel_a;
  assign forward_B = reset ? 2'b00 : sel_b;
  assign stall_F   = !reset && (md_stall || lw_eff);
  assign stall_D   = !reset && (md_stall || lw_eff);
  assign stall_E   = !reset && md_stall;
  assign flush_M   = !reset && md_stall;
  assign flush_D   = !reset && br_eff;
  assign flush_E   = !reset && (br_eff || lw_eff);
  assign md_busy   = busy;

`ifdef HAZARD_PERF_EN
  // Saturating stall/flush cycle counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_F && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if ((flush_D || flush_E) && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed scoreboard bench for hazard_ctrl (MD_LATENCY = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, rs_E, rt_E;
  logic [4:0]  writereg_E, writereg_M, writereg_W;
  logic        regwrite_E, regwrite_M, regwrite_W;
  logic        memtoreg_E, pcsrc_E, md_start_E;
  logic [1:0]  forward_A, forward_B;
  logic        stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, md_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  logic [10:0] got;
  logic [10:0] exp_q[$];
  string       name_q[$];
  logic [10:0] mon_exp;
  string       mon_name;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .rs_D       (rs_D),
    .rt_D       (rt_D),
    .rs_E       (rs_E),
    .rt_E       (rt_E),
    .writereg_E (writereg_E),
    .writereg_M (writereg_M),
    .writereg_W (writereg_W),
    .regwrite_E (regwrite_E),
    .regwrite_M (regwrite_M),
    .regwrite_W (regwrite_W),
    .memtoreg_E (memtoreg_E),
    .pcsrc_E    (pcsrc_E),
    .md_start_E (md_start_E),
    .forward_A  (forward_A),
    .forward_B  (forward_B),
    .stall_F    (stall_F),
    .stall_D    (stall_D),
    .stall_E    (stall_E),
    .flush_D    (flush_D),
    .flush_E    (flush_E),
    .flush_M    (flush_M),
    .md_busy    (md_busy)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  assign got = {forward_A, forward_B, stall_F, stall_D, stall_E,
                flush_D, flush_E, flush_M, md_busy};

  // Pack an expected output set in the same order as 'got'
  function automatic logic [10:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic sf, input logic sd, input logic se,
                                     input logic fd, input logic fe, input logic fm,
                                     input logic bz);
    return {fa, fb, sf, sd, se, fd, fe, fm, bz};
  endfunction

  task automatic expect_out(input string nm, input logic [10:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rs_D = 0; rt_D = 0; rs_E = 0; rt_E = 0;
    writereg_E = 0; writereg_M = 0; writereg_W = 0;
    regwrite_E = 0; regwrite_M = 0; regwrite_W = 0;
    memtoreg_E = 0; pcsrc_E = 0; md_start_E = 0;
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      total++;
      if (got !== mon_exp) begin
        bad++;
        $display("FAIL %s: got=%b expected=%b (fA fB sF sD sE fD fE fM busy)",
                 mon_name, got, mon_exp);
      end
    end
  end

  // Stimulus: set inputs just after posedge, push that cycle's expectation
  initial begin
    reset = 1'b1;
    clear_in();
    regwrite_M = 1; writereg_M = 5; rs_E = 5; md_start_E = 1;
    memtoreg_E = 1; regwrite_E = 1; writereg_E = 8; rt_D = 8;
    @(posedge clk); #1;
    expect_out("reset_outputs", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)); nxt();

    reset = 1'b0; clear_in();
    expect_out("idle", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)); nxt();

    // Forwarding
    regwrite_M = 1; writereg_M = 5; regwrite_W = 1; writereg_W = 5; rs_E = 5;
    expect_out("fwd_mem_prio", mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0)); nxt();
    regwrite_M = 0;
    expect_out("fwd_wb", mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0)); nxt();
    writereg_M = 0; writereg_W = 0; rs_E = 0;
    expect_out("fwd_reg0", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)); nxt();
    regwrite_M = 1; writereg_M = 7; writereg_W = 9; rs_E = 9; rt_E = 7;
    expect_out("fwd_split", mk(2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0)); nxt();
    regwrite_M = 0; writereg_W = 0; rt_E = 0;
    expect_out("fwd_none", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)); nxt();

    // Load-use
    clear_in();
    memtoreg_E = 1; regwrite_E = 1; writereg_E = 8; rt_D = 8;
    expect_out("lw_rt", mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0)); nxt();
    memtoreg_E = 0;
    expect_out("lw_clear", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)); nxt();
    memtoreg_E = 1; rt_D = 0; rs_D = 8;
    expect_out("lw_rs", mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0)); nxt();
    writereg_E = 0; rs_D = 0;
    expect_out("lw_reg0", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)); nxt();

    // Branch overrides load-use
    writereg_E = 8; rt_D = 8; pcsrc_E = 1;
    expect_out("branch_over_lw", mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0)); nxt();
    clear_in();
    expect_out("branch_clear", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)); nxt();

    // Mul/div held for MD_LATENCY=4: three stall cycles, busy in the last two
    md_start_E = 1;
    expect_out("md_issue", mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0)); nxt();
    expect_out("md_busy1", mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1)); nxt();
    expect_out("md_busy2", mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1)); nxt();
    expect_out("md_advance", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)); nxt();
    md_start_E = 0;
    expect_out("md_after", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)); nxt();

    // Mul/div together with load-use: load-use returns after BUSY
    md_start_E = 1; memtoreg_E = 1; regwrite_E = 1; writereg_E = 8; rt_D = 8;
    expect_out("mdlw_issue", mk(2'b00, 2'b00, 1, 1, 1, 0, 1, 1, 0)); nxt();
    expect_out("mdlw_busy1", mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1)); nxt();
    expect_out("mdlw_busy2", mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1)); nxt();
    expect_out("mdlw_lw_again", mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0)); nxt();
    clear_in();
    expect_out("mdlw_clear", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)); nxt();

    // Taken branch blocks a mul/div issue
    md_start_E = 1; pcsrc_E = 1;
    expect_out("md_branch", mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0)); nxt();
    clear_in();
    expect_out("md_branch_clear", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)); nxt();

    // Reset in the first BUSY cycle
    md_start_E = 1;
    expect_out("rst_md_issue", mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0)); nxt();
    reset = 1'b1; md_start_E = 0;
    expect_out("rst_mid_busy", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)); nxt();
    reset = 1'b0;
    expect_out("rst_released", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)); nxt();
    regwrite_W = 1; writereg_W = 3; rs_E = 3;
    expect_out("rst_alive", mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0)); nxt();
    clear_in();

    // One load-use cycle and one branch cycle
    memtoreg_E = 1; regwrite_E = 1; writereg_E = 8; rt_D = 8;
    expect_out("perf_lw", mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0)); nxt();
    clear_in();
    expect_out("perf_gap", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)); nxt();
    pcsrc_E = 1;
    expect_out("perf_br", mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0)); nxt();
    clear_in();
    expect_out("perf_end", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)); nxt();

`ifdef HAZARD_PERF_EN
    total++;
    if (perf_stall_cnt !== 32'd1) begin
      bad++;
      $display("FAIL perf_stall_cnt: got=%0d expected=1", perf_stall_cnt);
    end
    total++;
    if (perf_flush_cnt !== 32'd2) begin
      bad++;
      $display("FAIL perf_flush_cnt: got=%0d expected=2", perf_flush_cnt);
    end
`endif

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) nxt();
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
